// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types, constants and helpers for the 7-segment scan controller.
package seg_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // Nibble the decoder renders as all segments dark.
  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Widest display the suppress helper supports.
  localparam int MAX_DIGITS = 16;

  // Per-digit suppress vector: bit i is set when digit i and every digit
  // above it are zero. Digit 0 is never suppressed so a zero value still
  // shows a single "0". Only the lowest n digits are considered.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [4*MAX_DIGITS-1:0] value,
    input int                      n
  );
    logic [MAX_DIGITS-1:0] m;
    logic                  all_zero;
    m        = '0;
    all_zero = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (i < n) begin
        all_zero = all_zero & (value[4*i +: 4] == 4'h0);
        m[i]     = all_zero & (i != 0);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Value-load handshake between the value source and the scan controller.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
) ();

  logic                      load_valid;
  logic [4*NUM_DIGITS-1:0]   load_value;
  logic                      load_ready;

  // Value source side.
  modport master (
    output load_valid,
    output load_value,
    input  load_ready
  );

  // Scan controller side.
  modport slave (
    input  load_valid,
    input  load_value,
    output load_ready
  );

endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit
// 7-segment display. One digit is lit per slot, separated by a short dark
// gap; a shadow register makes value updates land on frame boundaries only.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  lz_en,
  seg_scan_ctrl_if.slave        ld,
  output logic [3:0]            bcd_out,
  output logic [NUM_DIGITS-1:0] dig_en_n,
  output logic                  frame_done
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int DW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW      = 4 * NUM_DIGITS;

  localparam logic [CW-1:0]         DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [DW-1:0]         LAST_DIGIT = DW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ALL_OFF    = '1;

  state_t                  state;
  logic [DW-1:0]           digit;
  logic [CW-1:0]           cnt;
  logic [VW-1:0]           active;
  logic [VW-1:0]           pending;
  logic                    pend_vld;

  logic [4*MAX_DIGITS-1:0] active_ext;
  logic [MAX_DIGITS-1:0]   lz_vec;
  logic [3:0]              digit_idx;
  logic [3:0]              cur_nib;
  logic [3:0]              show_nib;
  logic                    frame_end;

  // Shadow slot is free whenever nothing is waiting for a frame boundary.
  assign ld.load_ready = ~pend_vld;

  // Nibble for the current digit, with leading-zero blanking applied.
  always_comb begin
    active_ext = (4*MAX_DIGITS)'(active);
    lz_vec     = lz_mask(active_ext, NUM_DIGITS);
    digit_idx  = 4'(digit);
    cur_nib    = active[{digit, 2'b00} +: 4];
    show_nib   = (lz_en && lz_vec[digit_idx]) ? BLANK_CODE : cur_nib;
    frame_end  = (state == SHOW) && (cnt == DWELL_LAST) && (digit == LAST_DIGIT);
  end

  // Scan FSM with registered anode/nibble outputs and shadow commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= OFF;
      digit      <= '0;
      cnt        <= '0;
      active     <= '0;
      pend_vld   <= 1'b0;
      dig_en_n   <= ALL_OFF;
      bcd_out    <= BLANK_CODE;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!en) begin
        // Abandon the frame immediately; the shadow value is kept.
        state    <= OFF;
        digit    <= '0;
        cnt      <= '0;
        dig_en_n <= ALL_OFF;
        bcd_out  <= BLANK_CODE;
      end else begin
        case (state)
          OFF: begin
            state <= BLANK;
            digit <= '0;
            cnt   <= '0;
          end
          BLANK: begin
            if (cnt == BLANK_LAST) begin
              // Anode and nibble switch on the same edge, never stale.
              state    <= SHOW;
              cnt      <= '0;
              dig_en_n <= ALL_OFF ^ (NUM_DIGITS'(1) << digit);
              bcd_out  <= show_nib;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          SHOW: begin
            if (cnt == DWELL_LAST) begin
              state    <= BLANK;
              cnt      <= '0;
              dig_en_n <= ALL_OFF;
              bcd_out  <= BLANK_CODE;
              if (digit == LAST_DIGIT) begin
                digit      <= '0;
                frame_done <= 1'b1;
              end else begin
                digit <= digit + DW'(1);
              end
            end else begin
              // Keep tracking lz_en while the digit stays lit.
              cnt     <= cnt + CW'(1);
              bcd_out <= show_nib;
            end
          end
          default: state <= OFF;
        endcase
      end

      // Commit and accept are exclusive: accept needs the slot empty.
      if (frame_end && en && pend_vld) begin
        active   <= pending;
        pend_vld <= 1'b0;
      end else if (ld.load_valid && !pend_vld) begin
        pend_vld <= 1'b1;
      end
    end
  end

  // Shadow data capture on an accepted load.
  always_ff @(posedge clk) begin
    if (ld.load_valid && !pend_vld) begin
      pending <= ld.load_value;
    end
  end

endmodule
